// File: rtl/wb_pkg.sv
// Shared widths and the buffered-write entry type for the register-file write buffer.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// One register-file read-port lookup: finds the youngest stored entry whose rd matches addr.
module wb_match
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]        entries,
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [$clog2(DEPTH):0]       count,
    input  logic [REG_ADDR_W-1:0]        addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Walk from head (oldest) toward tail; later matches overwrite, leaving the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr != '0 && CNT_W'(i) < count &&
                entries[head + PTR_W'(i)].rd == addr) begin
                hit  = 1'b1;
                data = entries[head + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/wb_write_buffer.sv
// Circular FIFO of pending register-file writes, drained one per cycle unless held.
// Optional read-port bypass lookup is enabled by defining WB_WRITE_BUFFER_BYPASS_EN.
module wb_write_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [REG_ADDR_W-1:0]       in_rd,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        hold,
    output logic [REG_ADDR_W-1:0]       RW,
    output logic [DATA_W-1:0]           PW,
    output logic                        LE,
    input  logic [REG_ADDR_W-1:0]       RA,
    input  logic [REG_ADDR_W-1:0]       RB,
    input  logic [REG_ADDR_W-1:0]       RC,
    output logic                        hitA,
    output logic                        hitB,
    output logic                        hitC,
    output logic [DATA_W-1:0]           fwdA,
    output logic [DATA_W-1:0]           fwdB,
    output logic [DATA_W-1:0]           fwdC,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  pop;
    logic                  push;
    logic                  store;

    assign pop      = (count != '0) && !hold;
    assign in_ready = (count < CNT_W'(DEPTH)) || pop;
    assign push     = in_valid && in_ready;
    // A write to r0 is handshaken but dropped, since r0 is never written.
    assign store    = push && (in_rd != '0);

    assign LE = pop;
    assign RW = (count != '0) ? mem[head].rd   : '0;
    assign PW = (count != '0) ? mem[head].data : '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store) begin
                mem[tail] <= '{rd: in_rd, data: in_data};
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(store) - CNT_W'(pop);
        end
    end

`ifdef WB_WRITE_BUFFER_BYPASS_EN
    wb_match #(.DEPTH(DEPTH)) u_match_a (
        .entries(mem), .head(head), .count(count), .addr(RA), .hit(hitA), .data(fwdA)
    );
    wb_match #(.DEPTH(DEPTH)) u_match_b (
        .entries(mem), .head(head), .count(count), .addr(RB), .hit(hitB), .data(fwdB)
    );
    wb_match #(.DEPTH(DEPTH)) u_match_c (
        .entries(mem), .head(head), .count(count), .addr(RC), .hit(hitC), .data(fwdC)
    );
`else
    assign hitA = 1'b0;
    assign hitB = 1'b0;
    assign hitC = 1'b0;
    assign fwdA = '0;
    assign fwdB = '0;
    assign fwdC = '0;
`endif

endmodule
